control: RTL and testbench

// - Byte-stream frame controller for the comm path of the sparse-matrix accelerator.
// - Captures bytes from the serial receiver into an internal buffer until a 0x00 terminator arrives.
// - Then replays the frame one byte per clock on outData for the downstream loader.
// - ready=1 when idle and able to accept a new frame.

---
 rtl/control.sv | 150 +++++++++++++++
 tb/tb_control.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/control.sv
// Byte-stream frame controller: captures a 0x00-terminated frame into a
// local buffer, then replays it one byte per clock on outData.
//
// Handshake: there is no valid/ready pair on the receive side. A byte is
// taken on any rising edge where wen & dataReady is 1, and only while the
// controller is IDLE or LOAD. A byte offered during PLAY is dropped. ready
// is 1 exactly while the controller sits in IDLE. The replay side has no
// back-pressure: the downstream loader must take one byte per clock.
//
// Replay timing: terminator accepted at edge N. The buffer read is issued
// at edges N+1..N+len, and outData is loaded one edge after each read, at
// edges N+2..N+1+len. The edge that loads the last byte also returns the
// controller to IDLE and clears both pointers.
module control #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wen,
  input  logic        dataReady,
  input  logic [7:0]  inByte,
  output logic        ready,
  output logic [15:0] writePtr,
  output logic [15:0] readPtr,
  output logic [7:0]  outData,
  output logic [1:0]  debugState
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counters carry one extra bit so that a completely full 65536-byte
  // buffer is still distinguishable from an empty one.
  localparam logic [16:0] DEPTH_CNT = 17'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } stateT;

  stateT       state;
  stateT       stateNext;
  logic [16:0] wrCount;
  logic [16:0] wrCountNext;
  logic [16:0] rdCount;
  logic [16:0] rdCountNext;
  logic [7:0]  outNext;
  logic        readyNext;
  logic        rdValid;
  logic        rdValidNext;
  logic        memWe;
  logic        rdEn;
  logic [7:0]  memRd;
  logic [7:0]  mem [DEPTH];
  logic        accept;
  logic [AW-1:0] wrAddr;
  logic [AW-1:0] rdAddr;

  assign accept     = wen & dataReady;
  assign wrAddr     = wrCount[AW-1:0];
  assign rdAddr     = rdCount[AW-1:0];
  assign writePtr   = wrCount[15:0];
  assign readPtr    = rdCount[15:0];
  assign debugState = state;

  // Buffer RAM: one write port and one synchronous read port, no reset.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[wrAddr] <= inByte;
    end
    if (rdEn) begin
      memRd <= mem[rdAddr];
    end
  end

  // Next-state and datapath decisions for the capture/replay sequence.
  always_comb begin
    stateNext   = state;
    wrCountNext = wrCount;
    rdCountNext = rdCount;
    outNext     = outData;
    rdValidNext = 1'b0;
    memWe       = 1'b0;
    rdEn        = 1'b0;
    case (state)
      IDLE: begin
        // A lone 0x00 is an empty frame and is ignored.
        if (accept && (inByte != 8'h00)) begin
          memWe       = 1'b1;
          wrCountNext = 17'd1;
          stateNext   = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          if (inByte != 8'h00) begin
            // Once the buffer is full further data bytes are dropped.
            if (wrCount < DEPTH_CNT) begin
              memWe       = 1'b1;
              wrCountNext = wrCount + 17'd1;
            end
          end else begin
            // The terminator itself is never stored.
            rdCountNext = 17'd0;
            stateNext   = PLAY;
          end
        end
      end
      PLAY: begin
        if (rdCount < wrCount) begin
          rdEn        = 1'b1;
          rdValidNext = 1'b1;
          rdCountNext = rdCount + 17'd1;
        end
        if (rdValid) begin
          outNext = memRd;
        end
        // memRd holds the final byte once every address has been read.
        if (rdValid && (rdCount == wrCount)) begin
          stateNext   = IDLE;
          wrCountNext = 17'd0;
          rdCountNext = 17'd0;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
    readyNext = (stateNext == IDLE);
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wrCount <= 17'd0;
      rdCount <= 17'd0;
      outData <= 8'h00;
      ready   <= 1'b1;
      rdValid <= 1'b0;
    end else begin
      state   <= stateNext;
      wrCount <= wrCountNext;
      rdCount <= rdCountNext;
      outData <= outNext;
      ready   <= readyNext;
      rdValid <= rdValidNext;
    end
  end

endmodule

// File: tb/tb_control.sv
// Bench for control: drives byte frames and checks replay against a
// frame-level model of the controller.
module tb_control;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wen;
  logic        dataReady;
  logic [7:0]  inByte;
  logic        ready;
  logic [15:0] writePtr;
  logic [15:0] readPtr;
  logic [7:0]  outData;
  logic [1:0]  debugState;

  control #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .wen(wen),
    .dataReady(dataReady),
    .inByte(inByte),
    .ready(ready),
    .writePtr(writePtr),
    .readPtr(readPtr),
    .outData(outData),
    .debugState(debugState)
  );

  // Clock and cycle count (cyc = number of rising edges so far).
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Frame-level model.
  logic [7:0] frameQ[$];
  bit         loading  = 1'b0;
  int         termCyc  = -100;
  int         playLen  = 0;
  int         idleFrom = 0;
  logic [7:0] lastOut  = 8'h00;

  // Scoreboard: expected replay bytes with the edge that should load each.
  logic [7:0] exp_q[$];
  int         expT[$];

  logic [7:0] txQ[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    loading  = 1'b0;
    frameQ.delete();
    exp_q.delete();
    expT.delete();
    lastOut  = 8'h00;
    termCyc  = -100;
    playLen  = 0;
    idleFrom = cyc;
  endtask

  task automatic modelAccept(input logic [7:0] b);
    if (loading) begin
      if (b != 8'h00) begin
        if (frameQ.size() < DEPTH) frameQ.push_back(b);
      end else begin
        loading  = 1'b0;
        termCyc  = cyc;
        playLen  = frameQ.size();
        idleFrom = cyc + 1 + playLen;
        for (int k = 0; k < playLen; k++) begin
          exp_q.push_back(frameQ[k]);
          expT.push_back(cyc + 2 + k);
        end
      end
    end else if (cyc > idleFrom && b != 8'h00) begin
      frameQ.delete();
      frameQ.push_back(b);
      loading = 1'b1;
    end
  endtask

  // Driver: one clock of stimulus, model updated right after the edge.
  task automatic step(input bit w, input bit dr, input logic [7:0] b);
    @(negedge clk);
    wen       = w;
    dataReady = dr;
    inByte    = b;
    @(posedge clk);
    cyc++;
    if (w && dr && !reset) modelAccept(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  // Sends txQ as data bytes followed by a terminator.
  task automatic sendFrame();
    for (int i = 0; i < txQ.size(); i++) step(1'b1, 1'b1, txQ[i]);
    step(1'b1, 1'b1, 8'h00);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic asyncReset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_ready", int'(ready), 1);
    check("rst_writePtr", int'(writePtr), 0);
    check("rst_readPtr", int'(readPtr), 0);
    check("rst_outData", int'(outData), 0);
    modelReset();
    step(1'b0, 1'b0, 8'h00);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compares every output against the model on each falling edge.
  always @(negedge clk) begin
    int expWp;
    int expRp;
    bit expReady;
    if (expT.size() != 0 && expT[0] == cyc) begin
      void'(expT.pop_front());
      lastOut = exp_q.pop_front();
    end
    expReady = !loading && (cyc >= idleFrom);
    if (loading) expWp = frameQ.size();
    else if (cyc < idleFrom) expWp = playLen;
    else expWp = 0;
    if (!loading && cyc > termCyc && cyc <= termCyc + playLen) expRp = cyc - termCyc;
    else expRp = 0;
    check("outData", int'(outData), int'(lastOut));
    check("ready", int'(ready), int'(expReady));
    check("writePtr", int'(writePtr), expWp);
    check("readPtr", int'(readPtr), expRp);
  end

  initial begin
    reset     = 1'b1;
    wen       = 1'b0;
    dataReady = 1'b0;
    inByte    = 8'h00;
    modelReset();
    #1;
    check("init_ready", int'(ready), 1);
    check("init_outData", int'(outData), 0);
    idle(2);
    reset = 1'b0;
    idle(2);

    // Single-byte frame.
    txQ = '{8'h08};
    sendFrame();
    idle(4);

    // Three-byte frame.
    txQ = '{8'h10, 8'h18, 8'h20};
    sendFrame();
    idle(6);

    // Terminators while idle are empty frames.
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h00);
    idle(2);

    // dataReady without wen stores nothing, idle and mid-frame.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h55);
    step(1'b1, 1'b1, 8'h31);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h55);
    step(1'b1, 1'b1, 8'h32);
    step(1'b1, 1'b1, 8'h00);
    idle(5);

    // Overflow: six bytes into a four-byte buffer.
    txQ = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    sendFrame();
    idle(7);

    // Reset in the middle of a replay, then a fresh frame.
    txQ = '{8'h61, 8'h62, 8'h63, 8'h64};
    sendFrame();
    idle(2);
    asyncReset();
    txQ = '{8'h2A};
    sendFrame();
    idle(4);

    // Randomized frames with gaps and traffic during replay.
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0)
          step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        step(1'b1, 1'b1, 8'($urandom_range(1, 255)));
      end
      step(1'b1, 1'b1, 8'h00);
      for (int i = 0, n = $urandom_range(0, 8); i < n; i++)
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 9) == 0) asyncReset();
    end

    // Let any pending frame finish and drain the scoreboard.
    step(1'b1, 1'b1, 8'h00);
    idle(12);
    check("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
